// File: rtl/two_level_dirp.sv
// Two-level local-history direction predictor: per-entry history (bht) selects a saturating counter (pht).
// Latency: 1 cycle from lk_valid to pred_valid on every port; one lookup per port per cycle.
// Backpressure: none, lookups and updates are always accepted; DIRP_FWD_EN enables same-cycle update forwarding.
module two_level_dirp #(
  parameter int N_ENTRY  = 16,
  parameter int HIST_LEN = 2,
  parameter int CTR_BITS = 2,
  parameter int N_PORT   = 2,
  localparam int IDX_W   = $clog2(N_ENTRY)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_PORT-1:0]         lk_valid,
  input  logic [N_PORT*IDX_W-1:0]   lk_idx,
  input  logic                      up_valid,
  input  logic                      up_taken,
  input  logic [IDX_W-1:0]          up_idx,
  output logic [N_PORT-1:0]         pred_valid,
  output logic [N_PORT-1:0]         pred_taken
);

  // Counter table is flattened: address is {entry index, history pattern}.
  localparam int PHT_N = N_ENTRY << HIST_LEN;
  localparam int PW    = IDX_W + HIST_LEN;
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  logic [HIST_LEN-1:0] bht [N_ENTRY];
  logic [CTR_BITS-1:0] pht [PHT_N];

  logic [HIST_LEN-1:0] up_hist;
  logic [HIST_LEN-1:0] up_hist_nxt;
  logic [PW-1:0]       up_pidx;
  logic [CTR_BITS-1:0] up_ctr;
  logic [CTR_BITS-1:0] up_ctr_nxt;
  logic [N_PORT-1:0]   taken_nxt;

  // Update path: read addressed entry, shift in the outcome, saturate the counter.
  always_comb begin
    up_hist     = bht[up_idx];
    up_pidx     = {up_idx, up_hist};
    up_ctr      = pht[up_pidx];
    up_hist_nxt = HIST_LEN'({up_hist, up_taken});
    up_ctr_nxt  = up_ctr;
    if (up_taken) begin
      if (up_ctr != CTR_MAX) up_ctr_nxt = up_ctr + 1'b1;
    end else begin
      if (up_ctr != '0) up_ctr_nxt = up_ctr - 1'b1;
    end
  end

  // Lookup path: per-port history read then counter MSB as the prediction.
  always_comb begin
    taken_nxt = '0;
    for (int p = 0; p < N_PORT; p++) begin
      logic [IDX_W-1:0]    li;
      logic [HIST_LEN-1:0] lh;
      logic [CTR_BITS-1:0] lc;
      li = lk_idx[p*IDX_W +: IDX_W];
      lh = bht[li];
      lc = pht[{li, lh}];
`ifdef DIRP_FWD_EN
      // Same-entry update this cycle: predict from the post-update history and counters.
      if (up_valid && (up_idx == li)) begin
        lh = up_hist_nxt;
        if (lh == up_hist) lc = up_ctr_nxt;
        else               lc = pht[{li, lh}];
      end
`endif
      taken_nxt[p] = lc[CTR_BITS-1];
    end
  end

  // Table state: cleared on reset, otherwise one addressed entry/counter per update.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_ENTRY; i++) bht[i] <= '0;
      for (int j = 0; j < PHT_N; j++)   pht[j] <= '0;
    end else if (up_valid) begin
      bht[up_idx]  <= up_hist_nxt;
      pht[up_pidx] <= up_ctr_nxt;
    end
  end

  // Registered prediction outputs; taken is masked by valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      pred_valid <= '0;
      pred_taken <= '0;
    end else begin
      pred_valid <= lk_valid;
      pred_taken <= lk_valid & taken_nxt;
    end
  end

endmodule
